// File: rtl/while_inv_pkg.sv
// Shared definitions for the while_inv block: FSM state encoding, the
// compile-time modular inverse used as the multiplier constant, and the
// parameter validity check for the paired WhileEnt loop count.
package while_inv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Newton iteration for the inverse of odd k modulo 2^nbits. Starting from
  // inv = k gives 3 correct low bits (k*k == 1 mod 8 for any odd k), and each
  // step doubles the number of correct bits, so ceil(log2(nbits)) steps are
  // enough. Arithmetic is done mod 2^32; the caller truncates to nbits.
  function automatic logic [31:0] kinv(input logic [31:0] k, input int nbits);
    logic [31:0] inv;
    inv = k;
    for (int i = 0; i < $clog2(nbits); i++) begin
      inv = inv * (32'd2 - k * inv);
    end
    return inv;
  endfunction

  // K = COUNT + 1 is only invertible mod 2^n when it is odd.
  function automatic bit count_ok(input int count);
    return (count >= 0) && ((count % 2) == 0);
  endfunction

endpackage

// File: rtl/while_inv_mul_iter.sv
// Serial shift-add multiplier, one multiplier bit per cycle, fixed NBITS-cycle
// latency (no early exit when the multiplier runs out of ones).
//   clk, rst   : clock, synchronous active-high reset
//   start      : load mcand_in/mult_in and begin (ignored while busy)
//   busy       : iterating
//   done       : high during the final iteration cycle; prod is final after it
//   prod       : running product, wraps mod 2^NBITS
module mul_iter #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] mcand_in,
  input  logic [NBITS-1:0] mult_in,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] prod
);
  import while_inv_pkg::*;

  localparam int CNT_W = $clog2(NBITS + 1);

  logic [NBITS-1:0] mcand_q;
  logic [NBITS-1:0] mult_q;
  logic [NBITS-1:0] prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(NBITS - 1));
  assign prod = prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mult_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (!busy_q) begin
      if (start) begin
        mcand_q <= mcand_in;
        mult_q  <= mult_in;
        prod_q  <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else begin
      if (mult_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q <= mcand_q << 1;
      mult_q  <= mult_q >> 1;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/while_inv.sv
// Inverse of WhileEnt (XOUT = K*A - B mod 2^NBITS, K = COUNT+1): recovers
// A = KINV*(XIN + B) with a serial multiplier, then re-applies the forward
// function and reports agreement on OK.
//   CLK, RST            : clock, synchronous active-high reset
//   IN_VALID/IN_READY   : request handshake carrying XIN and B
//   OUT_VALID/OUT_READY : result handshake carrying AOUT and OK
module while_inv
  import while_inv_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int COUNT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [NBITS-1:0] XIN,
  input  logic [NBITS-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [NBITS-1:0] AOUT,
  output logic             OK
);

  if (!count_ok(COUNT)) begin : g_bad_count
    $error("while_inv: COUNT must be even so that K = COUNT+1 is odd");
  end

  localparam logic [NBITS-1:0] K_VAL = NBITS'(COUNT + 1);
  localparam logic [NBITS-1:0] KINV  = NBITS'(kinv(32'(COUNT + 1), NBITS));

  state_t           state_q, state_d;
  logic [NBITS-1:0] x_q, b_q;
  logic [NBITS-1:0] aout_q;
  logic             ok_q;
  logic             out_valid_q;

  logic             accept;
  logic [NBITS-1:0] mcand_init;
  logic [NBITS-1:0] prod;
  logic [NBITS-1:0] fwd;
  logic             mul_busy, mul_done;

  assign IN_READY   = (state_q == IDLE);
  assign accept     = IN_READY && IN_VALID;
  assign mcand_init = XIN + B;
  assign fwd        = K_VAL * prod - b_q;

  assign OUT_VALID = out_valid_q;
  assign AOUT      = aout_q;
  assign OK        = ok_q;

  mul_iter #(.NBITS(NBITS)) u_mul (
    .clk      (CLK),
    .rst      (RST),
    .start    (accept),
    .mcand_in (mcand_init),
    .mult_in  (KINV),
    .busy     (mul_busy),
    .done     (mul_done),
    .prod     (prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (IN_VALID) state_d = MUL;
      // The multiplier can only be idle here if it was never started, in
      // which case there is nothing to wait for.
      MUL: begin
        if (mul_done)       state_d = CHECK;
        else if (!mul_busy) state_d = IDLE;
      end
      CHECK: state_d = DONE;
      DONE:  if (OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      x_q         <= '0;
      b_q         <= '0;
      aout_q      <= '0;
      ok_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // capture request operands
      if (accept) begin
        x_q <= XIN;
        b_q <= B;
      end
      // self-check: forward function on the recovered operand
      if (state_q == CHECK) begin
        aout_q      <= prod;
        ok_q        <= (fwd == x_q);
        out_valid_q <= 1'b1;
      end
      // result handoff
      if (state_q == DONE && OUT_READY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_while_inv.sv
module tb_while_inv;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv0, ir0, ov0, or0, ok0;
  logic [7:0] xin0, b0, a0;
  logic       iv1, ir1, ov1, or1, ok1;
  logic [7:0] xin1, b1, a1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  while_inv #(.NBITS(8), .COUNT(4)) dut0 (
    .CLK(clk), .RST(rst), .IN_VALID(iv0), .IN_READY(ir0), .XIN(xin0), .B(b0),
    .OUT_VALID(ov0), .OUT_READY(or0), .AOUT(a0), .OK(ok0)
  );

  while_inv #(.NBITS(8), .COUNT(2)) dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(iv1), .IN_READY(ir1), .XIN(xin1), .B(b1),
    .OUT_VALID(ov1), .OUT_READY(or1), .AOUT(a1), .OK(ok1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the selected DUT; hold = cycles to keep
  // OUT_READY low in DONE, with a stray IN_VALID pulse inside that window.
  task automatic run(input bit sel, input logic [7:0] xin, input logic [7:0] b,
                     input logic [7:0] a_exp, input int hold);
    int n;
    logic [7:0] a_first;
    n = 0;
    while (!(sel ? ir1 : ir0) && n < 50) begin step(); n++; end
    chk("idle_before_accept", sel ? ir1 : ir0, 1);
    if (sel) begin iv1 = 1'b1; xin1 = xin; b1 = b; end
    else     begin iv0 = 1'b1; xin0 = xin; b0 = b; end
    step();
    // scramble inputs after acceptance; they must not matter
    if (sel) begin iv1 = 1'b0; xin1 = ~xin; b1 = 8'h5a; end
    else     begin iv0 = 1'b0; xin0 = ~xin; b0 = 8'h5a; end
    n = 1;
    while (!(sel ? ov1 : ov0) && n < 50) begin step(); n++; end
    chk("latency", n, 10);
    a_first = sel ? a1 : a0;
    chk("aout", a_first, a_exp);
    chk("ok", sel ? ok1 : ok0, 1);
    chk("in_ready_in_done", sel ? ir1 : ir0, 0);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin iv0 = 1'b1; xin0 = 8'd99; b0 = 8'd1; end
      if (i == 2) iv0 = 1'b0;
      step();
      chk("hold_aout", a0, a_exp);
      chk("hold_ok", ok0, 1);
      chk("hold_out_valid", ov0, 1);
      chk("hold_in_ready", ir0, 0);
    end
    if (sel) or1 = 1'b1; else or0 = 1'b1;
    step();
    if (sel) or1 = 1'b0; else or0 = 1'b0;
    chk("in_ready_after_handoff", sel ? ir1 : ir0, 1);
    chk("out_valid_after_handoff", sel ? ov1 : ov0, 0);
  endtask

  initial begin
    logic [7:0] a, b, x;
    int seen;
    rst = 1'b1;
    iv0 = 1'b1; xin0 = 8'd32; b0 = 8'd3; or0 = 1'b0;
    iv1 = 1'b1; xin1 = 8'd30; b1 = 8'd0; or1 = 1'b0;
    // requests presented during reset are dropped
    repeat (3) step();
    rst = 1'b0; iv0 = 1'b0; iv1 = 1'b0;
    chk("rst_in_ready", ir0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_aout", a0, 0);
    chk("rst_ok", ok0, 0);
    repeat (12) step();
    chk("rst_request_dropped", ov0, 0);
    chk("rst_request_dropped_k3", ov1, 0);

    run(1'b0, 8'd32,  8'd3,  8'd7,   0);
    run(1'b0, 8'd222, 8'd10, 8'd200, 0);
    run(1'b0, 8'd255, 8'd1,  8'd0,   0);
    run(1'b1, 8'd30,  8'd0,  8'd10,  0);

    // backpressure: 5 cycles in DONE, stray request ignored
    run(1'b0, 8'd32, 8'd3, 8'd7, 5);
    seen = 0;
    for (int i = 0; i < 14; i++) begin step(); if (ov0) seen++; end
    chk("stray_request_ignored", seen, 0);

    // leave a nonzero result in AOUT, then abort a request mid-multiply
    run(1'b0, 8'd222, 8'd10, 8'd200, 0);
    iv0 = 1'b1; xin0 = 8'd32; b0 = 8'd3;
    step();
    iv0 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", ir0, 1);
    chk("abort_out_valid", ov0, 0);
    chk("abort_aout", a0, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin step(); if (ov0) seen++; end
    chk("abort_no_result", seen, 0);

    // random sweep through the forward model
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      x = 8'd5 * a - b;
      run(1'b0, x, b, a, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
